// File: rtl/core_pkg.sv
// Shared RV32 core types: load funct3 encodings and the write-back FSM state.
`include "config.svh"

package core_pkg;
   localparam int XLEN   = `XLEN;
   localparam int REG_AW = `REG_AW;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } wb_state_e;
endpackage

// File: rtl/config.svh
// Core-wide build configuration: datapath width and register-address width.
`ifndef CONFIG_SVH
`define CONFIG_SVH
`define XLEN   32
`define REG_AW 5
`endif

// File: rtl/load_align.sv
// Load data aligner: picks the addressed byte/halfword and sign- or zero-extends it.
// Purely combinational; undefined load types yield zero.
module load_align
   import core_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      addr_lo,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] wdata
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{addr_lo, 3'b000} +: 8];
      half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];
      case (funct3)
         F3_LB:   wdata = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  wdata = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:   wdata = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  wdata = {{(XLEN-16){1'b0}}, half_sel};
         F3_LW:   wdata = rdata;
         default: wdata = '0;
      endcase
   end
endmodule

// File: rtl/wb_stage.sv
// RV32 write-back stage: one-slot holding register feeding the register-file write port.
// Accepts a new instruction in the same cycle the held one retires; WB_INSTRET_EN adds minstret.
module wb_stage
   import core_pkg::*;
#(
   parameter int INSTRET_W = 64
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_valid,
   output logic                 wb_ready,
   input  logic [REG_AW-1:0]    mem_rd_addr,
   input  logic                 mem_rd_write,
   input  logic                 mem_is_load,
   input  logic [2:0]           mem_funct3,
   input  logic [1:0]           mem_addr_lo,
   input  logic [XLEN-1:0]      mem_result,
   input  logic                 dmem_rvalid,
   input  logic [XLEN-1:0]      dmem_rdata,
   output logic [REG_AW-1:0]    rd_addr,
   output logic [XLEN-1:0]      rd_wdata,
   output logic                 rd_write,
`ifdef WB_INSTRET_EN
   output logic [INSTRET_W-1:0] minstret,
`endif
   output logic                 wb_busy
);
   wb_state_e          state_q;
   logic [REG_AW-1:0]  rd_addr_q;
   logic               rd_write_q;
   logic               is_load_q;
   logic [2:0]         funct3_q;
   logic [1:0]         addr_lo_q;
   logic [XLEN-1:0]    result_q;
   logic [XLEN-1:0]    load_data;
   logic               retire;
   logic               xfer;

   assign retire   = (state_q == HOLD) && (!is_load_q || dmem_rvalid);
   assign wb_ready = (state_q == IDLE) || retire;
   assign xfer     = mem_valid && wb_ready;
   assign wb_busy  = (state_q == HOLD) && !retire;

   assign rd_addr  = rd_addr_q;
   assign rd_write = retire && rd_write_q && (rd_addr_q != '0);
   assign rd_wdata = is_load_q ? load_data : result_q;

   load_align u_align (
      .funct3  (funct3_q),
      .addr_lo (addr_lo_q),
      .rdata   (dmem_rdata),
      .wdata   (load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rd_addr_q  <= '0;
         rd_write_q <= 1'b0;
         is_load_q  <= 1'b0;
      end else begin
         if (xfer) begin
            state_q    <= HOLD;
            rd_addr_q  <= mem_rd_addr;
            rd_write_q <= mem_rd_write;
            is_load_q  <= mem_is_load;
            funct3_q   <= mem_funct3;
            addr_lo_q  <= mem_addr_lo;
            result_q   <= mem_result;
         end else if (retire) begin
            state_q <= IDLE;
         end
      end
   end

`ifdef WB_INSTRET_EN
   logic [INSTRET_W-1:0] instret_q;

   // Counts every retire, including x0 targets and non-writing instructions.
   always_ff @(posedge clk) begin
      if (rst)
         instret_q <= '0;
      else if (retire)
         instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
   end

   assign minstret = instret_q;
`endif

   a_rvalid_ctx: assert property (@(posedge clk) disable iff (rst)
      dmem_rvalid |-> (state_q == HOLD && is_load_q));
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the RV32 pipeline, directly upstream of the register file write port. Captures the retiring instruction from the MEM stage, waits for load data when needed, aligns and extends load data, and drives the register file write port for exactly one cycle per retiring instruction. Also exports the retiring write as a forwarding source and optionally counts retired instructions.

## Interface
- `INSTRET_W`, default 64: width of the retired-instruction counter; used only with `WB_INSTRET_EN`.
- `clk` input 1: core clock.
- `rst` input 1: synchronous, active-high reset.
- `mem_valid` input 1: MEM stage presents an instruction.
- `wb_ready` output 1: WB can accept. Transfer occurs when `mem_valid && wb_ready`.
- `mem_rd_addr` input `REG_AW`: destination register.
- `mem_rd_write` input 1: instruction writes `rd`.
- `mem_is_load` input 1: instruction is a load.
- `mem_funct3` input 3: load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- `mem_addr_lo` input 2: load byte offset.
- `mem_result` input `XLEN`: ALU/CSR/link result for non-loads.
- `dmem_rvalid` input 1: load response valid.
- `dmem_rdata` input `XLEN`: raw load response word.
- `rd_addr` output `REG_AW`: register file write address.
- `rd_wdata` output `XLEN`: register file write data.
- `rd_write` output 1: register file write enable.
- `wb_busy` output 1: WB holds an instruction whose result is not yet written; used by hazard logic.
- `minstret` output `INSTRET_W`: retired-instruction count. Present only with `WB_INSTRET_EN`.

## Operation
- The stage is one register slot plus a two-state FSM:
  - IDLE: the slot is empty.
  - HOLD: the slot holds an instruction.
- Transition IDLE→HOLD on a transfer.
- In HOLD, the instruction retires when `!is_load_q || dmem_rvalid`. A non-load retires in its first HOLD cycle. A load waits in HOLD until `dmem_rvalid`.
- On retire:
  - With a same-cycle transfer, the FSM stays in HOLD with the new instruction.
  - Without a transfer, the FSM returns to IDLE.
- `wb_ready = (state==IDLE) || retire`. A new instruction is accepted in the same cycle the old one retires.
- `rd_write = retire && rd_write_q && (rd_addr_q != 0)`. x0 is never written. `rd_addr = rd_addr_q`.
- Write data:
  - Non-load: `rd_wdata = result_q`.
  - Load: `rd_wdata` is `dmem_rdata` aligned by the `load_align` sub-module.
- Load alignment:
  - Byte loads select the byte at `addr_lo_q*8`.
  - Halfword loads select bits `[addr_lo_q[1]*16 +: 16]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Alignment is guaranteed upstream; halfword uses only `addr_lo_q[1]`, and LW ignores `addr_lo_q`.
- Undefined funct3 values (011, 110, 111) produce `rd_wdata = 0`.
- `dmem_rvalid` while IDLE, or while HOLD holds a non-load, is ignored and fires a simulation assertion.
- `wb_busy = (state==HOLD) && !retire`.

## Timing
- Reset values: state IDLE, slot valid 0, `wb_ready=1`, `rd_write=0`, `rd_addr=0`, `wb_busy=0`, `minstret=0`. Slot data registers are don't-care.
- Non-load transferred at edge ending cycle N: `rd_write` is high during cycle N+1, and the register file updates at the end of N+1. Throughput is one per cycle.
- Load transferred at end of cycle N with response in cycle N+k (k≥1): `rd_write` is high in cycle N+k, and `wb_ready` is low in cycles N+1 .. N+k-1.
- The response is never earlier than the first HOLD cycle.
- `rd_*` are combinational from the slot registers and `dmem_*`. `wb_ready` is combinational from state, `is_load_q` and `dmem_rvalid`; it never depends on `mem_valid`.
- Reset asserted mid-load discards the held instruction without a write. A response arriving after reset is ignored.

## Configuration
- `WB_INSTRET_EN` defined:
  - `minstret` port and counter exist.
  - The counter increments by 1 on every retire, including x0 and `rd_write_q=0` instructions.
  - It wraps modulo 2^`INSTRET_W`.
- `WB_INSTRET_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `core_pkg` holds:
  - the funct3 load encodings as `localparam`s;
  - the `wb_state_e` enum (IDLE, HOLD).
- `XLEN` and `REG_AW` come from `config.svh`.
- One combinational sub-module, `load_align`, with inputs funct3, addr_lo and rdata, and output wdata.

## Test plan
- Non-load x5 ← 0x1234_5678 transferred in cycle 1 → `rd_write=1`, `rd_addr=5`, `rd_wdata=0x1234_5678` in cycle 2 only. Back-to-back non-loads write in consecutive cycles with `wb_ready` constantly 1.
- LB, addr_lo=3, rdata 0x80FF_0011, response 3 cycles after transfer → `wb_ready=0` for 2 cycles, then write 0xFFFF_FF80. With LBU, same stimulus → 0x0000_0080.
- LH, addr_lo=2, rdata 0x8001_7FFF → 0xFFFF_8001. LHU, addr_lo=0, same rdata → 0x0000_7FFF.
- Non-load with rd=0 and `rd_write=1` → `rd_write` stays 0. `minstret` still increments by 1 when `WB_INSTRET_EN` is defined.
- Reset asserted while a load waits, then `dmem_rvalid` pulsed → no write, `wb_ready=1`, `minstret=0`.
- Retire and new transfer in the same cycle (load response plus next `mem_valid`) → both instructions write in consecutive cycles with no bubble.
